// File: rtl/prog_mem_pkg.sv
// -----------------------------------------------------------------------------
// prog_mem_pkg
// Shared definitions for the loadable program memory: default geometry,
// the NOP instruction word and the loader session state encoding.
// -----------------------------------------------------------------------------
package prog_mem_pkg;

  localparam int unsigned DEF_DATA_W = 14;
  localparam int unsigned DEF_ADDR_W = 11;
  localparam logic [DEF_DATA_W-1:0] DEF_NOP_WORD = 14'h0000;

  // Loader session states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ld_state_e;

endpackage

// File: rtl/prog_mem_array.sv
// -----------------------------------------------------------------------------
// prog_mem_array
// Single-clock RAM with one synchronous write port and one synchronous read
// port. The array carries no reset so that firmware survives a core reset;
// power-up contents come from the device configuration (all-zero, which is
// the NOP word).
//
// Ports:
//   i_clk    clock, all state on the rising edge
//   i_we     write enable
//   i_waddr  write word address
//   i_wdata  write data
//   i_re     read enable; o_rdata holds its value while low
//   i_raddr  read word address
//   o_rdata  registered read data (one cycle after i_re)
// -----------------------------------------------------------------------------
module prog_mem_array
  import prog_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Write port: store one word per enabled cycle
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port: registered read, holds the last word when not enabled
  always_ff @(posedge i_clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/prog_mem_loadable.sv
// -----------------------------------------------------------------------------
// prog_mem_loadable
// Program memory for the soft-core fetch path with a registered fetch port
// and a streaming loader port for run-time firmware updates.
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_fetch_en/addr     fetch request and word address
//   o_fetch_data/valid  fetched word (1-cycle latency) and its valid flag
//   i_ld_start/base     open a load session at the given base address
//   i_ld_valid/data     loader word and its valid
//   i_ld_last           marks the final word of the session
//   o_ld_ready          loader may transfer (LOAD state)
//   o_ld_busy           session in progress (LOAD or DONE)
//   o_ld_count          words written in the current/last session
//   o_ld_checksum       sum of written words modulo 2**DATA_W
//   o_ld_err            sticky: a word was offered past the top address
// -----------------------------------------------------------------------------
module prog_mem_loadable
  import prog_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter logic [DATA_W-1:0] NOP_WORD = DEF_NOP_WORD
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_fetch_en,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  output logic [DATA_W-1:0] o_fetch_data,
  output logic              o_fetch_valid,
  input  logic              i_ld_start,
  input  logic [ADDR_W-1:0] i_ld_base,
  input  logic              i_ld_valid,
  input  logic [DATA_W-1:0] i_ld_data,
  input  logic              i_ld_last,
  output logic              o_ld_ready,
  output logic              o_ld_busy,
  output logic [ADDR_W:0]   o_ld_count,
  output logic [DATA_W-1:0] o_ld_checksum,
  output logic              o_ld_err
);

  ld_state_e         r_state;
  // MSB set means the pointer has run past the top address; no wrap to 0
  logic [ADDR_W:0]   r_wr_ptr;
  logic              r_ld_ready;
  logic              r_ld_busy;
  logic [ADDR_W:0]   r_ld_count;
  logic [DATA_W-1:0] r_ld_checksum;
  logic              r_ld_err;
  logic              r_fetch_valid;
  // Forces the NOP word onto the fetch output after reset or a refused fetch
  logic              r_fetch_nop;

  logic              w_idle;
  logic              w_xfer;
  logic              w_in_range;
  logic              w_we;
  logic              w_rd_en;
  logic [DATA_W-1:0] w_rd_data;

  assign w_idle     = (r_state == IDLE);
  assign w_xfer     = i_ld_valid & r_ld_ready;
  assign w_in_range = ~r_wr_ptr[ADDR_W];
  assign w_we       = w_xfer & w_in_range;
  // Fetches are only served from IDLE, so reads never collide with writes
  assign w_rd_en    = i_fetch_en & w_idle;

  prog_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr[ADDR_W-1:0]),
    .i_wdata (i_ld_data),
    .i_re    (w_rd_en),
    .i_raddr (i_fetch_addr),
    .o_rdata (w_rd_data)
  );

  // Loader session FSM with its pointer, counters and handshake outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_wr_ptr      <= '0;
      r_ld_ready    <= 1'b0;
      r_ld_busy     <= 1'b0;
      r_ld_count    <= '0;
      r_ld_checksum <= '0;
      r_ld_err      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_ld_start) begin
            r_state       <= LOAD;
            r_wr_ptr      <= {1'b0, i_ld_base};
            r_ld_count    <= '0;
            r_ld_checksum <= '0;
            r_ld_err      <= 1'b0;
            r_ld_ready    <= 1'b1;
            r_ld_busy     <= 1'b1;
          end
        end
        LOAD: begin
          // ld_start is deliberately not looked at here
          if (w_xfer) begin
            if (w_in_range) begin
              r_wr_ptr      <= r_wr_ptr + (ADDR_W+1)'(1);
              r_ld_count    <= r_ld_count + (ADDR_W+1)'(1);
              r_ld_checksum <= r_ld_checksum + i_ld_data;
            end else begin
              r_ld_err      <= 1'b1;
            end
            if (i_ld_last) begin
              r_state    <= DONE;
              r_ld_ready <= 1'b0;
            end
          end
        end
        DONE: begin
          r_state   <= IDLE;
          r_ld_busy <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_ld_ready <= 1'b0;
          r_ld_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Fetch qualifier: the state before the edge decides accept or refuse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_valid <= 1'b0;
      r_fetch_nop   <= 1'b1;
    end else if (i_fetch_en) begin
      r_fetch_valid <= w_idle;
      r_fetch_nop   <= ~w_idle;
    end else begin
      // No request: drop valid, leave the data path (and NOP mask) as is
      r_fetch_valid <= 1'b0;
    end
  end

  assign o_fetch_data  = r_fetch_nop ? NOP_WORD : w_rd_data;
  assign o_fetch_valid = r_fetch_valid;
  assign o_ld_ready    = r_ld_ready;
  assign o_ld_busy     = r_ld_busy;
  assign o_ld_count    = r_ld_count;
  assign o_ld_checksum = r_ld_checksum;
  assign o_ld_err      = r_ld_err;

endmodule

// File: tb/tb_prog_mem_loadable.sv
// -----------------------------------------------------------------------------
// tb_prog_mem_loadable
// Directed and randomized checks of prog_mem_loadable against a behavioural
// model: a plain array of memory words plus session count/sum/error values.
// -----------------------------------------------------------------------------
module tb_prog_mem_loadable;

  localparam int DW = 14;
  localparam int AW = 11;
  localparam int DEPTH = 2048;

  logic          clk;
  logic          rst_n;
  logic          fetch_en;
  logic [AW-1:0] fetch_addr;
  logic [DW-1:0] fetch_data;
  logic          fetch_valid;
  logic          ld_start;
  logic [AW-1:0] ld_base;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          ld_busy;
  logic [AW:0]   ld_count;
  logic [DW-1:0] ld_checksum;
  logic          ld_err;

  prog_mem_loadable dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_fetch_en    (fetch_en),
    .i_fetch_addr  (fetch_addr),
    .o_fetch_data  (fetch_data),
    .o_fetch_valid (fetch_valid),
    .i_ld_start    (ld_start),
    .i_ld_base     (ld_base),
    .i_ld_valid    (ld_valid),
    .i_ld_data     (ld_data),
    .i_ld_last     (ld_last),
    .o_ld_ready    (ld_ready),
    .o_ld_busy     (ld_busy),
    .o_ld_count    (ld_count),
    .o_ld_checksum (ld_checksum),
    .o_ld_err      (ld_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model
  logic [DW-1:0] mem_m [DEPTH];
  int            m_count;
  logic [DW-1:0] m_sum;
  logic          m_err;
  logic [DW-1:0] lw [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_fetch_data"},  32'(fetch_data),  32'h0);
    chk({pfx, "_fetch_valid"}, 32'(fetch_valid), 32'h0);
    chk({pfx, "_ld_ready"},    32'(ld_ready),    32'h0);
    chk({pfx, "_ld_busy"},     32'(ld_busy),     32'h0);
    chk({pfx, "_ld_count"},    32'(ld_count),    32'h0);
    chk({pfx, "_ld_checksum"}, 32'(ld_checksum), 32'h0);
    chk({pfx, "_ld_err"},      32'(ld_err),      32'h0);
  endtask

  task automatic fetch_chk(input logic [AW-1:0] a);
    fetch_en   = 1'b1;
    fetch_addr = a;
    tick();
    fetch_en   = 1'b0;
    chk("fetch_valid", 32'(fetch_valid), 32'h1);
    chk("fetch_data",  32'(fetch_data),  32'(mem_m[a]));
  endtask

  task automatic async_reset(input string pfx);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    fetch_en = 1'b0;
    ld_start = 1'b0;
    rst_n    = 1'b0;
    #2;
    chk_reset_vals(pfx);
    m_count = 0;
    m_sum   = '0;
    m_err   = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  // One loader session. gaps: idle cycle before every word carrying a
  // refused fetch and an ignored ld_start. rst_after: reset before word k.
  task automatic load_session(input logic [AW-1:0] base, input int n,
                              input bit gaps, input int rst_after);
    int ptr;
    logic [AW-1:0] fa;
    fa         = AW'($urandom_range(0, DEPTH-1));
    ld_start   = 1'b1;
    ld_base    = base;
    fetch_en   = 1'b1;
    fetch_addr = fa;
    tick();
    ld_start   = 1'b0;
    fetch_en   = 1'b0;
    chk("start_fetch_valid", 32'(fetch_valid), 32'h1);
    chk("start_fetch_data",  32'(fetch_data),  32'(mem_m[fa]));
    m_count = 0;
    m_sum   = '0;
    m_err   = 1'b0;
    ptr     = int'(base);
    chk("start_ready",    32'(ld_ready),    32'h1);
    chk("start_busy",     32'(ld_busy),     32'h1);
    chk("start_count",    32'(ld_count),    32'h0);
    chk("start_checksum", 32'(ld_checksum), 32'h0);
    chk("start_err",      32'(ld_err),      32'h0);
    for (int i = 0; i < n; i++) begin
      if (i == rst_after) begin
        async_reset("midrst");
        return;
      end
      if (gaps) begin
        ld_valid   = 1'b0;
        fetch_en   = 1'b1;
        fetch_addr = 11'h001;
        ld_start   = 1'b1;
        ld_base    = AW'($urandom_range(0, DEPTH-1));
        tick();
        fetch_en   = 1'b0;
        ld_start   = 1'b0;
        chk("refused_valid", 32'(fetch_valid), 32'h0);
        chk("refused_data",  32'(fetch_data),  32'h0);
        chk("gap_ready",     32'(ld_ready),    32'h1);
        chk("gap_count",     32'(ld_count),    32'(m_count));
      end
      ld_valid = 1'b1;
      ld_data  = lw[i];
      ld_last  = (i == n-1);
      tick();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      if (ptr < DEPTH) begin
        mem_m[ptr] = lw[i];
        m_count++;
        m_sum = m_sum + lw[i];
        ptr++;
      end else begin
        m_err = 1'b1;
      end
      chk("xfer_count",    32'(ld_count),    32'(m_count));
      chk("xfer_checksum", 32'(ld_checksum), 32'(m_sum));
      chk("xfer_err",      32'(ld_err),      32'(m_err));
    end
    chk("done_ready", 32'(ld_ready), 32'h0);
    chk("done_busy",  32'(ld_busy),  32'h1);
    tick();
    chk("idle_busy",     32'(ld_busy),     32'h0);
    chk("idle_ready",    32'(ld_ready),    32'h0);
    chk("idle_count",    32'(ld_count),    32'(m_count));
    chk("idle_checksum", 32'(ld_checksum), 32'(m_sum));
    chk("idle_err",      32'(ld_err),      32'(m_err));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] b;
    int n;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    m_count    = 0;
    m_sum      = '0;
    m_err      = 1'b0;
    rst_n      = 1'b0;
    fetch_en   = 1'b0;
    fetch_addr = '0;
    ld_start   = 1'b0;
    ld_base    = '0;
    ld_valid   = 1'b0;
    ld_data    = '0;
    ld_last    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("por");
    rst_n = 1'b1;
    tick();

    // Power-up contents are NOP
    fetch_chk(11'h000);
    fetch_chk(AW'($urandom_range(1, DEPTH-1)));

    // Directed session at base 0
    lw[0] = 14'h300F; lw[1] = 14'h00A4; lw[2] = 14'h01A5;
    load_session(11'h000, 3, 1'b0, -1);
    chk("A_count",    32'(ld_count),    32'h3);
    chk("A_checksum", 32'(ld_checksum), 32'h3258);
    fetch_chk(11'h001);
    chk("A_word1", 32'(fetch_data), 32'h00A4);
    // No request: valid drops, data holds
    tick();
    chk("hold_valid", 32'(fetch_valid), 32'h0);
    chk("hold_data",  32'(fetch_data),  32'h00A4);

    // Overflow at the top of memory, no wrap
    lw[0] = 14'h2803; lw[1] = 14'h2800; lw[2] = 14'h3400;
    load_session(11'h7FE, 3, 1'b0, -1);
    chk("B_err",   32'(ld_err),   32'h1);
    chk("B_count", 32'(ld_count), 32'h2);
    fetch_chk(11'h000);
    chk("B_addr0", 32'(fetch_data), 32'h300F);
    fetch_chk(11'h7FE);
    fetch_chk(11'h7FF);
    chk("B_err_sticky", 32'(ld_err), 32'h1);

    // ld_valid every other cycle, with refused fetches and ignored ld_start
    for (int i = 0; i < 4; i++) lw[i] = DW'($urandom);
    b = AW'($urandom_range(16, 2000));
    load_session(b, 4, 1'b1, -1);
    chk("C_count", 32'(ld_count), 32'h4);
    for (int k = 0; k < 4; k++) fetch_chk(b + AW'(k));

    // Random sessions, the first placed near the top of memory
    for (int s = 0; s < 4; s++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) lw[i] = DW'($urandom);
      b = (s == 0) ? AW'($urandom_range(DEPTH-4, DEPTH-1))
                   : AW'($urandom_range(0, DEPTH-1));
      load_session(b, n, bit'($urandom_range(0, 1)), -1);
      for (int k = 0; k < n; k++)
        if (int'(b) + k < DEPTH) fetch_chk(b + AW'(k));
    end

    // Reset after 2 of 5 words: outputs reset, written words retained
    for (int i = 0; i < 5; i++) lw[i] = DW'($urandom);
    b = AW'($urandom_range(0, 2000));
    load_session(b, 5, 1'b0, 2);
    fetch_chk(b);
    fetch_chk(b + 11'h001);
    chk("R_word0", 32'(fetch_data), 32'(lw[1]));
    chk("R_count", 32'(ld_count), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
